q_mst_rsp: RTL
==============

# q_mst_rsp

Packet responder for the `q` master command/response interface. It consumes the sop/eop-framed 128-bit command packets that `q` drives on its master command port, and executes reads and writes against an internal beat-addressed memory. It returns sop/eop-framed 128-bit response packets suitable for the `q` master response port. It is the far-end model and target for the master interface, used as a memory target in integration benches and as the backing responder in standalone builds.

## Interface
- `DEPTH`, 256: memory depth in 128-bit words; must be a power of 2, at least 2. The index is `addr[$clog2(DEPTH)-1:0]`.
- `clk` in 1: sole clock; all state is updated on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `i_cmd_vld` in 1: command beat valid. There is no backpressure; every valid beat is consumed or dropped.
- `i_cmd_sop` in 1: first beat of a command packet.
- `i_cmd_eop` in 1: last beat of a command packet.
- `i_cmd_dat` in 128: command beat payload.
- `o_rsp_vld` out 1: response beat valid.
- `o_rsp_sop` out 1: first response beat.
- `o_rsp_eop` out 1: last response beat.
- `o_rsp_dat` out 128: response beat payload.
- `o_busy` out 1: high whenever the state is not IDLE.
- `o_drop` out 1: sticky flag; set when any beat is discarded unprocessed. Cleared only by reset.

## Operation
Command header (sop beat) fields:
- `[127:120]` opcode: 0x01 READ, 0x02 WRITE.
- `[119:112]` len: data beats, 1..255.
- `[63:0]` addr.

Command forms:
- READ is a single beat, sop=eop=1.
- WRITE is the header followed by exactly len data beats; eop is on the last data beat.

Response header fields:
- `[127:120]` opcode: 0x81 read data, 0x82 write ack, 0xFF error.
- `[119:112]` len echoed.
- `[111:104]` error code: 0 none, 1 bad opcode, 2 len==0, 3 length mismatch.
- `[63:0]` addr echoed.

States: IDLE, WR, DRAIN, RD_HDR, RD_DAT, ACK, ERR.

Transitions out of IDLE on a vld&sop beat:
- READ with len≠0 and eop → RD_HDR.
- WRITE with len≠0 and !eop → WR.
- Otherwise with eop → ERR.
- Otherwise with !eop → DRAIN.
- The error code is latched: opcode not 0x01/0x02 gives 1; len==0 gives 2; READ without eop or WRITE with eop gives 3.

WR state, data beat k (k = 0..len-1):
- Writes `mem[(addr+k) mod DEPTH]`.
- eop with k==len-1 → ACK.
- eop with k<len-1 → ERR, code 3; beats already written remain written.
- k==len-1 without eop → DRAIN, code 3; surplus beats are not written.
- A vld&sop beat in WR terminates the write (that beat is not written) and sets `o_drop`. The next state is ERR with code 3. If that beat lacks eop, its packet is discarded through the drop flag.

DRAIN state: discards beats until eop, then → ERR.

Response states:
- RD_HDR emits the header with sop=1, then → RD_DAT.
- RD_DAT emits `mem[(addr+i) mod DEPTH]` for i = 0..len-1, with eop on i==len-1, then → IDLE.
- ACK emits one beat, sop=eop=1, then → IDLE.
- ERR emits one beat, sop=eop=1, then → IDLE.

Drop handling:
- A vld&sop beat arriving in any response state, or in IDLE's successor cycle, is discarded and sets `o_drop`.
- An internal drop-packet flag discards that packet's beats through eop.
- A vld beat without sop while in IDLE and not dropping is discarded and sets `o_drop`.

Further rules:
- Address arithmetic wraps modulo DEPTH; `addr` bits above the index are echoed but are otherwise ignored.
- Memory contents are not reset.

## Timing
- Reset: all outputs are 0, the state is IDLE, and the drop flag is clear. A reset asserted mid-packet or mid-response aborts: there are no response beats in the cycle after `rst`, and any partial write stays applied.
- Memory has a 1-cycle synchronous read; the read address is issued one cycle ahead so that RD_DAT beats are contiguous.
- READ accepted at cycle T: header at T+1, data at T+2..T+1+len, no gaps.
- WRITE with eop at T: ACK at T+1.
- ERR beat: in the cycle after the eop that closes the packet. For a sop-only terminating beat, in the cycle after that beat.
- Response beats are only emitted on contiguous cycles; `o_rsp_vld` is high exactly in response states.
- IDLE is re-entered in the cycle after the response eop beat. A new sop arriving in the same cycle as the response eop is dropped; the earliest accepted sop is response-eop+1.
- `o_busy` is registered from the state: high from the cycle after sop acceptance until the cycle after the response eop.

## Test plan
- WRITE addr=0x10, len=2, data A,B → ACK at eop+1 with dat[127:120]=0x82, len=2. Then READ addr=0x10, len=2 → header 0x81 at T+1, A at T+2, B at T+3 with eop; `o_drop` stays 0.
- Wrap: DEPTH=256, WRITE addr=0xFF, len=2, data C,D, then READ addr=0xFF, len=2 → returns C,D. A READ at addr=0 with len=1 returns D.
- Errors:
  - opcode 0x05 single beat → 0xFF response, code 1, at T+1.
  - READ with len=0 → code 2.
  - WRITE with len=3 and eop on the 2nd data beat → code 3; the two beats are written.
- Overlap: issue READ len=4 at T, then a sop&eop READ at T+3 → the second command is dropped, `o_drop`=1, and only one 5-beat response is emitted.
- Boundary: a sop at the response-eop cycle is dropped; the same sop one cycle later is accepted with its header response at +1.
- Reset during RD_DAT beat 2 of len=8 → `o_rsp_vld`=0 from the next cycle, `o_busy`=0, `o_drop`=0. A subsequent READ works normally.

Source files
------------

// File: rtl/q_mst_rsp.sv
// Packet responder for the q master interface: executes framed READ/WRITE
// commands against a beat-addressed memory and returns framed responses.
module q_mst_rsp #(
  parameter int DEPTH = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_cmd_vld,
  input  logic         i_cmd_sop,
  input  logic         i_cmd_eop,
  input  logic [127:0] i_cmd_dat,
  output logic         o_rsp_vld,
  output logic         o_rsp_sop,
  output logic         o_rsp_eop,
  output logic [127:0] o_rsp_dat,
  output logic         o_busy,
  output logic         o_drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_DRAIN, S_RD_HDR, S_RD_DAT, S_ACK, S_ERR
  } state_t;

  state_t         state_q, state_d;
  logic [63:0]    addr_q, addr_d;
  logic [7:0]     len_q, len_d;
  logic [7:0]     code_q, code_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           drop_q, drop_d;
  logic           dpkt_q, dpkt_d;
  logic           vld_q, sop_q, eop_q, busy_q;
  logic [127:0]   hdr_q, hdr_d;
  logic [127:0]   mem_q [DEPTH];
  logic [127:0]   rd_q;
  logic [AW-1:0]  idx;
  logic           wr_en;
  logic [7:0]     h_op, h_len, h_code;
  logic           h_rd, h_wr;

  assign h_op  = i_cmd_dat[127:120];
  assign h_len = i_cmd_dat[119:112];
  assign h_rd  = (h_op == 8'h01);
  assign h_wr  = (h_op == 8'h02);

  always_comb begin
    h_code = 8'd3;
    if (!(h_rd || h_wr))    h_code = 8'd1;
    else if (h_len == 8'd0) h_code = 8'd2;
  end

  // Shared beat index: write beat k in WR, read-ahead pointer in RD_HDR/RD_DAT.
  assign idx   = addr_q[AW-1:0] + AW'(cnt_q);
  assign wr_en = (state_q == S_WR) && i_cmd_vld && !i_cmd_sop && !rst;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    dpkt_d  = dpkt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (i_cmd_vld && i_cmd_sop) begin
          dpkt_d = 1'b0;
          addr_d = i_cmd_dat[63:0];
          len_d  = h_len;
          code_d = h_code;
          if (h_rd && h_len != 8'd0 && i_cmd_eop)       state_d = S_RD_HDR;
          else if (h_wr && h_len != 8'd0 && !i_cmd_eop) state_d = S_WR;
          else if (i_cmd_eop)                           state_d = S_ERR;
          else                                          state_d = S_DRAIN;
        end else if (i_cmd_vld) begin
          if (dpkt_q) dpkt_d = !i_cmd_eop;
          else        drop_d = 1'b1;
        end
      end
      S_WR: begin
        if (i_cmd_vld && i_cmd_sop) begin
          drop_d  = 1'b1;
          dpkt_d  = !i_cmd_eop;
          code_d  = 8'd3;
          state_d = S_ERR;
        end else if (i_cmd_vld) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) begin
            if (i_cmd_eop) state_d = S_ACK;
            else begin
              code_d  = 8'd3;
              state_d = S_DRAIN;
            end
          end else if (i_cmd_eop) begin
            code_d  = 8'd3;
            state_d = S_ERR;
          end
        end
      end
      S_DRAIN: begin
        if (i_cmd_vld && i_cmd_sop) drop_d = 1'b1;
        if (i_cmd_vld && i_cmd_eop) state_d = S_ERR;
      end
      S_RD_HDR: begin
        cnt_d   = 8'd1;
        state_d = S_RD_DAT;
      end
      S_RD_DAT: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == len_q) state_d = S_IDLE;
      end
      S_ACK, S_ERR: state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    // Anything arriving while a response is on the wire is discarded.
    if (vld_q && i_cmd_vld) begin
      drop_d = 1'b1;
      if (i_cmd_sop)      dpkt_d = !i_cmd_eop;
      else if (i_cmd_eop) dpkt_d = 1'b0;
    end
  end

  always_comb begin
    case (state_d)
      S_RD_HDR: hdr_d = {8'h81, len_d, 8'h00, 40'h0, addr_d};
      S_ACK:    hdr_d = {8'h82, len_d, 8'h00, 40'h0, addr_d};
      S_ERR:    hdr_d = {8'hFF, len_d, code_d, 40'h0, addr_d};
      default:  hdr_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      dpkt_q  <= 1'b0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      busy_q  <= 1'b0;
      hdr_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      dpkt_q  <= dpkt_d;
      vld_q   <= state_d inside {S_RD_HDR, S_RD_DAT, S_ACK, S_ERR};
      sop_q   <= state_d inside {S_RD_HDR, S_ACK, S_ERR};
      eop_q   <= (state_d == S_ACK) || (state_d == S_ERR) ||
                 ((state_d == S_RD_DAT) && (cnt_d == len_d));
      busy_q  <= (state_d != S_IDLE);
      hdr_q   <= hdr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx] <= i_cmd_dat;
    rd_q <= mem_q[idx];
  end

  assign o_rsp_vld = vld_q;
  assign o_rsp_sop = sop_q;
  assign o_rsp_eop = eop_q;
  assign o_rsp_dat = (state_q == S_RD_DAT) ? rd_q : hdr_q;
  assign o_busy    = busy_q;
  assign o_drop    = drop_q;

endmodule
